argmax_seq: RTL and testbench

Sequencer for the 16-lane signed max tree (`max16`). It accepts a job length, streams 16-lane input vectors beat by beat, and tags every lane with its global element index. It folds each beat's tree result into a running maximum and returns the final maximum value and its index. It serves argmax and global max-pool layers in the NPU core.

---
 rtl/argmax_seq.sv | 252 +++++++++++++++++++++++++
 tb/tb_argmax_seq.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/argmax_seq.sv
// ---------------------------------------------------------------------------
// argmax_seq -- job sequencer around a 16-lane signed max tree.
//
// A job of cfg_len elements arrives as ceil(cfg_len/16) beats of 16 lanes.
// The sequencer tags every lane with its global element index and feeds the
// {index, data} pairs to max16. It folds each beat's winner into a running
// maximum and reports the final maximum value and its index.
//
// Optional feature: define ARGMAX_SEQ_PIPE_EN to insert one register stage
// between the tree and the accumulator. The result then arrives one cycle
// later and throughput is unchanged.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset, aborts any job
//   start      job start pulse, honoured only in IDLE with cfg_len != 0
//   cfg_len    element count of the job, sampled with start
//   in_valid   input beat valid
//   in_ready   a beat is accepted when in_valid && in_ready
//   in_data    16 lanes, lane k in bits [k*Data_Width +: Data_Width]
//   out_valid  result valid, held until out_ready
//   out_ready  result consumed
//   out_max    maximum value (signed)
//   out_index  global index of the maximum
//   busy       job in progress (state != IDLE)
// ---------------------------------------------------------------------------

// max16: combinational 16-to-1 signed max over {index, data} pairs.
// On equal data the lower-numbered lane wins.
module max16 #(
    parameter int Data_Width  = 8,
    parameter int Index_Width = 16
) (
    input  logic [16*(Index_Width+Data_Width)-1:0] sub_data,
    output logic signed [Data_Width-1:0]           max_data,
    output logic [Index_Width-1:0]                 max_index
);
    localparam int SW = Index_Width + Data_Width;

    logic signed [Data_Width-1:0] l0_data [16];
    logic [Index_Width-1:0]       l0_idx  [16];
    logic signed [Data_Width-1:0] l1_data [8];
    logic [Index_Width-1:0]       l1_idx  [8];
    logic signed [Data_Width-1:0] l2_data [4];
    logic [Index_Width-1:0]       l2_idx  [4];
    logic signed [Data_Width-1:0] l3_data [2];
    logic [Index_Width-1:0]       l3_idx  [2];

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_leaf
            assign l0_data[gi] = sub_data[gi*SW +: Data_Width];
            assign l0_idx[gi]  = sub_data[gi*SW + Data_Width +: Index_Width];
        end
        for (gi = 0; gi < 8; gi++) begin : g_lvl1
            assign l1_data[gi] = (l0_data[2*gi] >= l0_data[2*gi+1]) ? l0_data[2*gi] : l0_data[2*gi+1];
            assign l1_idx[gi]  = (l0_data[2*gi] >= l0_data[2*gi+1]) ? l0_idx[2*gi]  : l0_idx[2*gi+1];
        end
        for (gi = 0; gi < 4; gi++) begin : g_lvl2
            assign l2_data[gi] = (l1_data[2*gi] >= l1_data[2*gi+1]) ? l1_data[2*gi] : l1_data[2*gi+1];
            assign l2_idx[gi]  = (l1_data[2*gi] >= l1_data[2*gi+1]) ? l1_idx[2*gi]  : l1_idx[2*gi+1];
        end
        for (gi = 0; gi < 2; gi++) begin : g_lvl3
            assign l3_data[gi] = (l2_data[2*gi] >= l2_data[2*gi+1]) ? l2_data[2*gi] : l2_data[2*gi+1];
            assign l3_idx[gi]  = (l2_data[2*gi] >= l2_data[2*gi+1]) ? l2_idx[2*gi]  : l2_idx[2*gi+1];
        end
    endgenerate

    assign max_data  = (l3_data[0] >= l3_data[1]) ? l3_data[0] : l3_data[1];
    assign max_index = (l3_data[0] >= l3_data[1]) ? l3_idx[0]  : l3_idx[1];
endmodule

module argmax_seq #(
    parameter int Data_Width  = 8,
    parameter int Index_Width = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [Index_Width-1:0]  cfg_len,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [16*Data_Width-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [Data_Width-1:0]   out_max,
    output logic [Index_Width-1:0]  out_index,
    output logic                    busy
);
    localparam int SW = Index_Width + Data_Width;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                       state_reg;
    logic [Index_Width-1:0]       len_reg;
    logic [Index_Width-1:0]       base_reg;      // global index of lane 0 = b*16
    logic                         first_reg;
    logic                         in_ready_reg;
    logic                         out_valid_reg;
    logic signed [Data_Width-1:0] acc_max_reg;
    logic [Index_Width-1:0]       acc_index_reg;
    logic [Data_Width-1:0]        out_max_reg;
    logic [Index_Width-1:0]       out_index_reg;

    logic                         accept;
    logic                         last_beat;
    logic [16*SW-1:0]             sub_data;
    logic signed [Data_Width-1:0] tree_max;
    logic [Index_Width-1:0]       tree_index;

    assign accept    = in_valid && in_ready_reg;
    // base < len always holds in RUN, so the subtraction never wraps.
    assign last_beat = (len_reg - base_reg) <= Index_Width'(16);

    // Lane tagging. Lanes past the end of the job mirror lane 0 (never
    // masked, since base < len), so they can only tie with lane 0 and the
    // winning index always stays inside the job.
    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_tag
            logic [Index_Width:0] elem_idx;
            logic                 masked;
            assign elem_idx = {1'b0, base_reg} + (Index_Width+1)'(gi);
            assign masked   = elem_idx >= {1'b0, len_reg};
            assign sub_data[gi*SW +: SW] = masked
                ? {base_reg, in_data[0 +: Data_Width]}
                : {elem_idx[Index_Width-1:0], in_data[gi*Data_Width +: Data_Width]};
        end
    endgenerate

    max16 #(
        .Data_Width  (Data_Width),
        .Index_Width (Index_Width)
    ) u_max16 (
        .sub_data  (sub_data),
        .max_data  (tree_max),
        .max_index (tree_index)
    );

    // Accumulator input: either straight from the tree or via one stage.
    logic                         acc_in_valid;
    logic                         acc_in_first;
    logic                         acc_in_last;
    logic signed [Data_Width-1:0] acc_in_max;
    logic [Index_Width-1:0]       acc_in_index;

`ifdef ARGMAX_SEQ_PIPE_EN
    logic                         pipe_valid_reg;
    logic                         pipe_first_reg;
    logic                         pipe_last_reg;
    logic signed [Data_Width-1:0] pipe_max_reg;
    logic [Index_Width-1:0]       pipe_index_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_valid_reg <= 1'b0;
            pipe_first_reg <= 1'b0;
            pipe_last_reg  <= 1'b0;
            pipe_max_reg   <= '0;
            pipe_index_reg <= '0;
        end else begin
            pipe_valid_reg <= accept;
            if (accept) begin
                pipe_first_reg <= first_reg;
                pipe_last_reg  <= last_beat;
                pipe_max_reg   <= tree_max;
                pipe_index_reg <= tree_index;
            end
        end
    end

    assign acc_in_valid = pipe_valid_reg;
    assign acc_in_first = pipe_first_reg;
    assign acc_in_last  = pipe_last_reg;
    assign acc_in_max   = pipe_max_reg;
    assign acc_in_index = pipe_index_reg;
`else
    assign acc_in_valid = accept;
    assign acc_in_first = first_reg;
    assign acc_in_last  = last_beat;
    assign acc_in_max   = tree_max;
    assign acc_in_index = tree_index;
`endif

    // Strictly-greater replacement keeps the earlier index on cross-beat ties.
    logic                         acc_take;
    logic signed [Data_Width-1:0] acc_max_next;
    logic [Index_Width-1:0]       acc_index_next;

    assign acc_take       = acc_in_first || (acc_in_max > acc_max_reg);
    assign acc_max_next   = acc_take ? acc_in_max   : acc_max_reg;
    assign acc_index_next = acc_take ? acc_in_index : acc_index_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            len_reg       <= '0;
            base_reg      <= '0;
            first_reg     <= 1'b0;
            in_ready_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
            acc_max_reg   <= '0;
            acc_index_reg <= '0;
            out_max_reg   <= '0;
            out_index_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start && (cfg_len != '0)) begin
                        len_reg      <= cfg_len;
                        base_reg     <= '0;
                        first_reg    <= 1'b1;
                        in_ready_reg <= 1'b1;
                        state_reg    <= RUN;
                    end
                end
                RUN: begin
                    if (accept) begin
                        base_reg  <= base_reg + Index_Width'(16);
                        first_reg <= 1'b0;
                        if (last_beat) begin
                            in_ready_reg <= 1'b0;
                        end
                    end
                    if (acc_in_valid) begin
                        acc_max_reg   <= acc_max_next;
                        acc_index_reg <= acc_index_next;
                        if (acc_in_last) begin
                            out_max_reg   <= acc_max_next;
                            out_index_reg <= acc_index_next;
                            out_valid_reg <= 1'b1;
                            state_reg     <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign out_max   = out_max_reg;
    assign out_index = out_index_reg;
    assign busy      = (state_reg != IDLE);
endmodule

// File: tb/tb_argmax_seq.sv
module tb_argmax_seq;
    logic         clk;
    logic         rst_n;
    logic         start;
    logic [15:0]  cfg_len;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [7:0]   out_max;
    logic [15:0]  out_index;
    logic         busy;

    int n_assert = 0;
    int n_fail   = 0;

    logic [127:0] vec;

    argmax_seq #(
        .Data_Width  (8),
        .Index_Width (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .cfg_len   (cfg_len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_max   (out_max),
        .out_index (out_index),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input logic [15:0] len);
        start   = 1'b1;
        cfg_len = len;
        step();
        start   = 1'b0;
        $display("job start cfg_len=%0d busy=%0b in_ready=%0b", len, busy, in_ready);
    endtask

    // Presents one beat after `gap` idle cycles and returns once it is accepted.
    task automatic send_beat(input logic [127:0] data, input int gap);
        int n;
        repeat (gap) begin
            in_valid = 1'b0;
            step();
        end
        in_valid = 1'b1;
        in_data  = data;
        n = 0;
        while (in_ready !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        if (in_ready !== 1'b1) check("in_ready_timeout", {31'b0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        $display("beat accepted data=%h", data);
    endtask

    // Called right after the last beat is accepted; checks result latency.
    task automatic expect_result(input string tag);
`ifdef ARGMAX_SEQ_PIPE_EN
        check({tag, "_lat_early"}, {31'b0, out_valid}, 32'd0);
        step();
`endif
        check({tag, "_out_valid"}, {31'b0, out_valid}, 32'd1);
        check({tag, "_in_ready_done"}, {31'b0, in_ready}, 32'd0);
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, "_valid_fall"}, {31'b0, out_valid}, 32'd0);
        check({tag, "_idle"}, {31'b0, busy}, 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        cfg_len   = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        vec       = '0;

        // ---------------- reset state
        step();
        step();
        check("rst_in_ready",  {31'b0, in_ready},  32'd0);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_busy",      {31'b0, busy},      32'd0);
        check("rst_out_max",   {24'b0, out_max},   32'd0);
        check("rst_out_index", {16'b0, out_index}, 32'd0);
        rst_n = 1'b1;
        step();

        // start with cfg_len = 0 is ignored
        start_job(16'd0);
        check("len0_ignored", {31'b0, busy}, 32'd0);

        // ---------------- T1: cfg_len=16, lane k = k-8 -> max 7 at 15
        start_job(16'd16);
        check("t1_busy", {31'b0, busy}, 32'd1);
        check("t1_in_ready", {31'b0, in_ready}, 32'd1);
        for (int k = 0; k < 16; k++) vec[k*8 +: 8] = 8'(k - 8);
        send_beat(vec, 0);
        expect_result("t1");
        check("t1_max",   {24'b0, out_max},   32'h07);
        check("t1_index", {16'b0, out_index}, 32'd15);
        $display("t1 result max=%0d index=%0d", $signed(out_max), out_index);
        handshake("t1");

        // ---------------- T2: cfg_len=40, masked 127s must not win
        start_job(16'd40);
        vec = {16{8'hFD}};
        send_beat(vec, 0);
        vec = {16{8'hFD}};
        vec[5*8 +: 8] = 8'd100;
        send_beat(vec, 0);
        vec = {16{8'hFD}};
        for (int k = 8; k < 16; k++) vec[k*8 +: 8] = 8'd127;
        send_beat(vec, 0);
        expect_result("t2");
        check("t2_max",   {24'b0, out_max},   32'd100);
        check("t2_index", {16'b0, out_index}, 32'd21);
        $display("t2 result max=%0d index=%0d", $signed(out_max), out_index);
        handshake("t2");

        // ---------------- T3: cross-beat tie keeps earlier index
        start_job(16'd32);
        vec = {16{8'hFF}};
        vec[3*8 +: 8] = 8'd50;
        send_beat(vec, 0);
        vec = {16{8'hFF}};
        vec[2*8 +: 8] = 8'd50;
        send_beat(vec, 0);
        expect_result("t3");
        check("t3_max",   {24'b0, out_max},   32'd50);
        check("t3_index", {16'b0, out_index}, 32'd3);
        $display("t3 result max=%0d index=%0d", $signed(out_max), out_index);
        handshake("t3");

        // ---------------- T4: all -128, cfg_len=20
        start_job(16'd20);
        vec = {16{8'h80}};
        send_beat(vec, 0);
        send_beat(vec, 0);
        expect_result("t4");
        check("t4_max", {24'b0, out_max}, 32'h80);
        check("t4_index_in_range", {31'b0, (out_index < 16'd20)}, 32'd1);
        $display("t4 result max=%0d index=%0d", $signed(out_max), out_index);
        handshake("t4");

        // ---------------- T5: backpressure, cfg_len=48
        // beat0 lanes = k (max 15), beat1 lane10 = 90, beat2 lane15 = 90 -> 90 at 26
        start_job(16'd48);
        for (int k = 0; k < 16; k++) vec[k*8 +: 8] = 8'(k);
        send_beat(vec, 1);
        start   = 1'b1;              // start during RUN
        cfg_len = 16'd16;
        step();
        start   = 1'b0;
        check("t5_start_in_run", {31'b0, busy}, 32'd1);
        vec = '0;
        vec[10*8 +: 8] = 8'd90;
        send_beat(vec, 1);
        vec = '0;
        vec[15*8 +: 8] = 8'd90;
        send_beat(vec, 1);
        expect_result("t5");
        start = 1'b1;                // start during DONE
        for (int c = 0; c < 5; c++) begin
            step();
            start = 1'b0;
            check("t5_hold_valid", {31'b0, out_valid}, 32'd1);
            check("t5_hold_max",   {24'b0, out_max},   32'd90);
            check("t5_hold_index", {16'b0, out_index}, 32'd26);
            check("t5_hold_ready", {31'b0, in_ready},  32'd0);
            $display("t5 hold cycle %0d max=%0d index=%0d", c, $signed(out_max), out_index);
        end
        start   = 1'b1;              // start in the handshake cycle
        cfg_len = 16'd16;
        handshake("t5");
        start = 1'b0;
        step();
        check("t5_start_hs_ignored", {31'b0, busy}, 32'd0);

        // ---------------- T6: async reset mid-job, then a clean job
        start_job(16'd64);
        vec = '0;
        vec[0 +: 8] = 8'd120;
        send_beat(vec, 0);
        vec = '0;
        send_beat(vec, 0);
        rst_n = 1'b0;
        #1;
        check("t6_rst_busy",      {31'b0, busy},      32'd0);
        check("t6_rst_in_ready",  {31'b0, in_ready},  32'd0);
        check("t6_rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("t6_rst_out_max",   {24'b0, out_max},   32'd0);
        check("t6_rst_out_index", {16'b0, out_index}, 32'd0);
        $display("t6 async reset applied busy=%0b out_max=%0d", busy, out_max);
        #2;
        rst_n = 1'b1;
        step();
        start_job(16'd16);
        vec = {16{8'hF6}};
        vec[9*8 +: 8] = 8'd5;
        send_beat(vec, 0);
        expect_result("t6");
        check("t6_max",   {24'b0, out_max},   32'd5);
        check("t6_index", {16'b0, out_index}, 32'd9);
        $display("t6 result max=%0d index=%0d", $signed(out_max), out_index);
        handshake("t6");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
